// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the data-side load/store unit.
//   - type_lsu2module_data_s : request bundle driven to a data slave
//   - type_module2lsu_s      : response bundle returned by a data slave
//   - lsu_state_e            : controller states
//   - F3_* localparams       : RV32I load/store funct3 encodings
//   - UART_REGION            : address nibble [31:28] of the UART window
//   - op_is_bad()            : funct3 legality check for loads and stores
package load_store_unit_pkg;

  typedef struct packed {
    logic [31:0] dbus_addr;
    logic [31:0] dbus;
    logic        wr_en;
    logic        rd_en;
    logic        sel;
  } type_lsu2module_data_s;

  typedef struct packed {
    logic [31:0] rd_data;
  } type_module2lsu_s;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    RMW_WR,
    UART_WAIT,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] UART_REGION = 4'h8;

  // Stores only have signed encodings (SB/SH/SW); loads add BU/HU.
  function automatic logic op_is_bad(input logic store, input logic [2:0] funct3);
    if (store) begin
      return !(funct3 inside {F3_LB, F3_LH, F3_LW});
    end
    return !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// Combinational data path helper for the load/store unit.
//   funct3     in  : access size / signedness
//   word       in  : word returned by the slave (lane 0 = accessed address)
//   wdata      in  : store data (rs2)
//   load_ext   out : lane 0 byte/half sign- or zero-extended, or full word
//   store_word out : word with the store byte/half merged into the low lanes
// The slave always returns bytes addr..addr+3, so the addressed byte is
// always lane 0 regardless of the address alignment.
module load_store_unit_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] store_word
);

  always_comb begin
    load_ext = word;
    case (funct3)
      F3_LB:   load_ext = {{24{word[7]}}, word[7:0]};
      F3_LH:   load_ext = {{16{word[15]}}, word[15:0]};
      F3_LBU:  load_ext = {24'h0, word[7:0]};
      F3_LHU:  load_ext = {16'h0, word[15:0]};
      default: load_ext = word;
    endcase
  end

  always_comb begin
    store_word = wdata;
    case (funct3)
      F3_LB:   store_word = {word[31:8], wdata[7:0]};
      F3_LH:   store_word = {word[31:16], wdata[15:0]};
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-side bus initiator: executes RV32I loads/stores towards Data_Mem or
// the UART, extends load results and stalls the pipeline until retirement.
// Byte/half stores to Data_Mem are read-modify-write because Data_Mem always
// writes four bytes at dbus_addr..dbus_addr+3.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid/store/funct3/addr/wdata  request from the memory stage
//   stall, done, load_data, err    pipeline handshake and result
//   lsu2dmem / dmem2lsu            Data_Mem request / combinational response
//   lsu2uart / uart2lsu / uart_ack UART request / response / acknowledge
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned H/W
// accesses with err instead of performing them.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter logic [31:0] UART_BASE   = {UART_REGION, 28'h0},
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           load_data,
  output logic                  err,
  output type_lsu2module_data_s lsu2dmem,
  input  type_module2lsu_s      dmem2lsu,
  output type_lsu2module_data_s lsu2uart,
  input  type_module2lsu_s      uart2lsu,
  input  logic                  uart_ack
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  lsu_state_e            state_reg;
  logic                  store_reg;
  logic [2:0]            funct3_reg;
  logic [31:0]           wdata_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic [31:0]           load_data_reg;
  type_lsu2module_data_s dmem_reg;
  type_lsu2module_data_s uart_reg;

  logic        is_uart;
  logic        misaligned;
  logic        reject;
  logic [31:0] slave_word;
  logic [31:0] load_ext;
  logic [31:0] store_word;

  assign is_uart = (req_addr[31:28] == UART_BASE[31:28]);

`ifdef LSU_MISALIGN_TRAP_EN
  // Store funct3 SH/SW share encodings with LH/LW.
  assign misaligned = ((req_funct3 == F3_LH || req_funct3 == F3_LHU) && req_addr[0]) ||
                      ((req_funct3 == F3_LW) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign reject = op_is_bad(req_store, req_funct3) || misaligned;

  // Request fields are latched at accept, so the extend/merge path sees the
  // accepted operation even if the stage drops req_valid mid-access.
  assign slave_word = (state_reg == UART_WAIT) ? uart2lsu.rd_data : dmem2lsu.rd_data;

  load_store_unit_extend u_extend (
    .funct3     (funct3_reg),
    .word       (slave_word),
    .wdata      (wdata_reg),
    .load_ext   (load_ext),
    .store_word (store_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      store_reg     <= 1'b0;
      funct3_reg    <= 3'b000;
      wdata_reg     <= 32'h0;
      cnt_reg       <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      load_data_reg <= 32'h0;
      dmem_reg      <= '0;
      uart_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            store_reg  <= req_store;
            funct3_reg <= req_funct3;
            wdata_reg  <= req_wdata;
            cnt_reg    <= '0;
            if (reject) begin
              load_data_reg <= 32'h0;
              done_reg      <= 1'b1;
              err_reg       <= 1'b1;
              state_reg     <= RESP;
            end else if (is_uart) begin
              uart_reg.dbus_addr <= req_addr;
              uart_reg.dbus      <= req_store ? req_wdata : 32'h0;
              uart_reg.wr_en     <= req_store;
              uart_reg.rd_en     <= !req_store;
              uart_reg.sel       <= 1'b1;
              state_reg          <= UART_WAIT;
            end else if (!req_store || req_funct3 != F3_LW) begin
              // Loads and the read half of SB/SH share the same read cycle.
              dmem_reg.dbus_addr <= req_addr;
              dmem_reg.dbus      <= 32'h0;
              dmem_reg.wr_en     <= 1'b0;
              dmem_reg.rd_en     <= 1'b1;
              dmem_reg.sel       <= 1'b1;
              state_reg          <= req_store ? RMW_RD : LOAD;
            end else begin
              dmem_reg.dbus_addr <= req_addr;
              dmem_reg.dbus      <= req_wdata;
              dmem_reg.wr_en     <= 1'b1;
              dmem_reg.rd_en     <= 1'b0;
              dmem_reg.sel       <= 1'b1;
              state_reg          <= RMW_WR;
            end
          end
        end
        LOAD: begin
          load_data_reg <= load_ext;
          dmem_reg      <= '0;
          done_reg      <= 1'b1;
          state_reg     <= RESP;
        end
        RMW_RD: begin
          dmem_reg.dbus  <= store_word;
          dmem_reg.rd_en <= 1'b0;
          dmem_reg.wr_en <= 1'b1;
          state_reg      <= RMW_WR;
        end
        RMW_WR: begin
          dmem_reg  <= '0;
          done_reg  <= 1'b1;
          state_reg <= RESP;
        end
        UART_WAIT: begin
          if (uart_ack) begin
            if (!store_reg) begin
              load_data_reg <= load_ext;
            end
            uart_reg  <= '0;
            done_reg  <= 1'b1;
            state_reg <= RESP;
          end else if (cnt_reg == CNT_W'(ACK_TIMEOUT - 1)) begin
            uart_reg  <= '0;
            done_reg  <= 1'b1;
            err_reg   <= 1'b1;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Stall rises combinationally in the accept cycle so the stage holds its
  // request; it is low in RESP so the pipeline advances with done.
  assign stall = ((state_reg == IDLE) && req_valid) ||
                 (state_reg inside {LOAD, RMW_RD, RMW_WR, UART_WAIT});

  assign done      = done_reg;
  assign err       = err_reg;
  assign load_data = load_data_reg;
  assign lsu2dmem  = dmem_reg;
  assign lsu2uart  = uart_reg;

endmodule
